// File: rtl/uart_dbg_pkg.sv
// Shared types and helpers for the test_value UART debug serializer.
//   tx_state_e   : byte serializer FSM states
//   ASCII_CR/LF  : line terminator characters
//   hex_to_ascii : 4-bit nibble -> uppercase hex ASCII character
package uart_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // 0-9 -> '0'-'9', A-F -> 'A'-'F'
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return 8'h30 + {4'h0, nibble};
    end
    return 8'h37 + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer, LSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   valid      : byte offered on data; accepted when valid & ready
//   data       : byte to send
//   ready      : high in idle and during the final cycle of a stop bit, so a
//                byte offered then starts with no gap after the stop bit
//   tx         : serial line, idle high
module uart_tx_byte
  import uart_dbg_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n;
  logic             tx_n;
  logic             ready_n;
  logic             tick_c;
  logic             accept_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      ready    <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
      ready    <= ready_n;
    end
  end

  // Next-state, line level and ready look-ahead
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    tx_n       = tx;
    tick_c     = (baud_cnt == CNT_LAST);
    accept_c   = valid & ready;

    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (accept_c) begin
          shreg_n    = data;
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          tx_n       = 1'b0;
          state_n    = START;
        end
      end
      START: begin
        if (tick_c) begin
          baud_cnt_n = '0;
          tx_n       = shreg[0];
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (tick_c) begin
          baud_cnt_n = '0;
          if (bit_cnt == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            shreg_n   = shreg >> 1;
            tx_n      = shreg[1];
          end
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (tick_c) begin
          baud_cnt_n = '0;
          if (accept_c) begin
            // back-to-back: next start bit follows this stop bit directly
            shreg_n   = data;
            bit_cnt_n = '0;
            tx_n      = 1'b0;
            state_n   = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase

    // ready is registered, so predict it from next-cycle state
    ready_n = (state_n == IDLE) || ((state_n == STOP) && (baud_cnt_n == CNT_LAST));
  end

endmodule

// File: rtl/test_value_uart_tx.sv
// Debug serializer for the core's 16-bit test_value: on every change or on
// force_send it transmits the value as four uppercase hex characters,
// optionally followed by CR LF, over an 8N1 UART line.
//   clk, rst    : clock, asynchronous active-low reset
//   test_value  : value watched for changes
//   force_send  : one-cycle request to resend the current value
//   tx          : UART line, idle high
//   busy        : high while a frame is in progress
//   frame_done  : one-cycle pulse after the last stop bit of a frame
module test_value_uart_tx
  import uart_dbg_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter bit          SEND_CRLF    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] test_value,
  input  logic        force_send,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [2:0] NUM_CHARS = SEND_CRLF ? 3'd6 : 3'd4;

  logic [15:0] prev_val, snap, snap_n;
  logic        pending, pending_n;
  logic [2:0]  char_idx, char_idx_n;
  logic        busy_n, frame_done_n;
  logic        change_c, start_c, valid_c, byte_ready;
  logic [7:0]  byte_c;

  // Character idx of a frame carrying val
  function automatic logic [7:0] char_at(input logic [15:0] val, input logic [2:0] idx);
    case (idx)
      3'd0:    return hex_to_ascii(val[15:12]);
      3'd1:    return hex_to_ascii(val[11:8]);
      3'd2:    return hex_to_ascii(val[7:4]);
      3'd3:    return hex_to_ascii(val[3:0]);
      3'd4:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk   (clk),
    .rst_n (rst),
    .valid (valid_c),
    .data  (byte_c),
    .ready (byte_ready),
    .tx    (tx)
  );

  // Frame control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_val   <= '0;
      pending    <= 1'b0;
      snap       <= '0;
      char_idx   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      prev_val   <= test_value;
      pending    <= pending_n;
      snap       <= snap_n;
      char_idx   <= char_idx_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

  // Change detection, frame start/end and character sequencing
  always_comb begin
    snap_n       = snap;
    char_idx_n   = char_idx;
    busy_n       = busy;
    frame_done_n = 1'b0;
    start_c      = 1'b0;
    valid_c      = 1'b0;
    byte_c       = char_at(snap, char_idx);
    change_c     = (test_value != prev_val);

    if (!busy) begin
      if (pending && byte_ready) begin
        // first character comes straight from test_value, snap holds the rest
        start_c    = 1'b1;
        valid_c    = 1'b1;
        byte_c     = char_at(test_value, 3'd0);
        snap_n     = test_value;
        char_idx_n = 3'd1;
        busy_n     = 1'b1;
      end
    end else if (byte_ready) begin
      if (char_idx < NUM_CHARS) begin
        valid_c    = 1'b1;
        char_idx_n = char_idx + 3'd1;
      end else begin
        char_idx_n   = '0;
        busy_n       = 1'b0;
        frame_done_n = 1'b1;
      end
    end

    // set wins over clear
    if (change_c || force_send) begin
      pending_n = 1'b1;
    end else if (start_c) begin
      pending_n = 1'b0;
    end else begin
      pending_n = pending;
    end
  end

endmodule
